// File: rtl/alu_op_issue.sv
// alu_op_issue: ID/EX pipeline register for the ALU interface.
// Decodes ID-stage fields into an ALU control code and operands, then holds
// them in a main register (drives ex_*) backed by a one-entry skid register
// so that id_ready can come straight from a flop.
// Optional feature macro: ALU_ISSUE_FWD_EN (EX/MEM result forwarding at capture).
module alu_op_issue #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_src_a,
  output logic [XLEN-1:0] ex_src_b,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [2:0]      ex_funct3,
  output logic            ex_illegal
);

  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b1110;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1111;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   rs2_data;
    logic [CTRL_W-1:0] alu_control;
    logic [2:0]        funct3;
    logic              illegal;
  } op_t;

  // Arithmetic code shared by OP and OP-IMM; SUB only exists for register form.
  function automatic logic [CTRL_W-1:0] arith_code(input logic [2:0] f3,
                                                   input logic       alt,
                                                   input logic       is_reg);
    logic [CTRL_W-1:0] code;
    code = ALU_ADD;
    case (f3)
      3'b000: code = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001: code = ALU_SLL;
      3'b010: code = ALU_SLT;
      3'b011: code = ALU_SLTU;
      3'b100: code = ALU_XOR;
      3'b101: code = alt ? ALU_SRA : ALU_SRL;
      3'b110: code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  op_t             dec;

  op_t  main_q, main_d;
  op_t  skid_q, skid_d;
  logic ex_valid_q, ex_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic id_ready_q, id_ready_d;
  logic accept, drain;

`ifdef ALU_ISSUE_FWD_EN
  // Replace register-file reads with the in-flight EX/MEM result when it matches.
  always_comb begin
    rs1_val = id_rs1_data;
    rs2_val = id_rs2_data;
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == id_rs1)) rs1_val = fwd_data;
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == id_rs2)) rs2_val = fwd_data;
  end
`else
  // Operands come straight from the register file; forwarding inputs are unused.
  always_comb begin
    rs1_val = id_rs1_data;
    rs2_val = id_rs2_data;
  end

  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, id_rs1, id_rs2};
`endif

  // Decode ID fields into the op payload captured by the pipeline register.
  always_comb begin
    dec             = '0;
    dec.funct3      = id_funct3;
    dec.rs2_data    = rs2_val;
    dec.alu_control = ALU_ADD;
    case (id_opcode)
      OPC_OP: begin
        dec.alu_control = arith_code(id_funct3, id_funct7_5, 1'b1);
        dec.src_a       = rs1_val;
        dec.src_b       = rs2_val;
      end
      OPC_OP_IMM: begin
        dec.alu_control = arith_code(id_funct3, id_funct7_5, 1'b0);
        dec.src_a       = rs1_val;
        dec.src_b       = id_imm;
      end
      OPC_LOAD, OPC_STORE: begin
        dec.src_a = rs1_val;
        dec.src_b = id_imm;
      end
      OPC_BRANCH: begin
        case (id_funct3[2:1])
          2'b10:   dec.alu_control = ALU_SLT;
          2'b11:   dec.alu_control = ALU_SLTU;
          default: dec.alu_control = ALU_SUB;
        endcase
        dec.src_a = rs1_val;
        dec.src_b = rs2_val;
      end
      OPC_LUI: begin
        dec.src_b = id_imm;
      end
      OPC_AUIPC: begin
        dec.src_a = id_pc;
        dec.src_b = id_imm;
      end
      OPC_JAL, OPC_JALR: begin
        dec.src_a = id_pc;
        dec.src_b = XLEN'(PC_STEP);
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign accept = id_valid && id_ready_q;
  assign drain  = ex_valid_q && ex_ready;

  // Main/skid next state: main refills from skid first to keep FIFO order.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    ex_valid_d   = ex_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      ex_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!ex_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        ex_valid_d   = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d     = dec;
        ex_valid_d = 1'b1;
      end else begin
        ex_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    id_ready_d = !skid_valid_d;
  end

  // State registers; reset discards any held ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      ex_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      id_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      ex_valid_q   <= ex_valid_d;
      skid_valid_q <= skid_valid_d;
      id_ready_q   <= id_ready_d;
    end
  end

  assign id_ready       = id_ready_q;
  assign ex_valid       = ex_valid_q;
  assign ex_src_a       = main_q.src_a;
  assign ex_src_b       = main_q.src_b;
  assign ex_alu_control = main_q.alu_control;
  assign ex_rs2_data    = main_q.rs2_data;
  assign ex_funct3      = main_q.funct3;
  assign ex_illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode, skid buffering, flush, reset, forwarding.
module tb_alu_op_issue;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_pc;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_src_a;
  logic [XLEN-1:0] ex_src_b;
  logic [3:0]      ex_alu_control;
  logic [XLEN-1:0] ex_rs2_data;
  logic [2:0]      ex_funct3;
  logic            ex_illegal;

  int errors = 0;
  int checks = 0;

  alu_op_issue #(.XLEN(XLEN), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_alu_control(ex_alu_control),
    .ex_rs2_data(ex_rs2_data), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc);
    id_valid    = 1'b1;
    id_opcode   = opc;
    id_funct3   = f3;
    id_funct7_5 = f7;
    id_rs1_data = a;
    id_rs2_data = b;
    id_imm      = imm;
    id_pc       = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    id_opcode = '0; id_funct3 = '0; id_funct7_5 = 1'b0;
    id_rs1 = 5'd1; id_rs2 = 5'd2;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_pc = '0;
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;

    // Reset state
    #12;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    check("rst_src_a", ex_src_a, 32'd0);
    check("rst_src_b", ex_src_b, 32'd0);
    check("rst_ctrl", 32'(ex_alu_control), 32'd0);
    check("rst_rs2_data", ex_rs2_data, 32'd0);
    check("rst_funct3", 32'(ex_funct3), 32'd0);
    check("rst_illegal", 32'(ex_illegal), 32'd0);
    rst_n = 1'b1;
    step();

    // 1: R-type SUB
    offer(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0);
    step();
    check("sub_valid", 32'(ex_valid), 32'd1);
    check("sub_ctrl", 32'(ex_alu_control), 32'b0010);
    check("sub_src_a", ex_src_a, 32'd10);
    check("sub_src_b", ex_src_b, 32'd3);
    check("sub_rs2_data", ex_rs2_data, 32'd3);

    // 2: SRAI, BLTU, BEQ back-to-back
    offer(7'b0010011, 3'b101, 1'b1, 32'h80, 32'h55, 32'd4, 32'd0);
    step();
    check("srai_ctrl", 32'(ex_alu_control), 32'b1111);
    check("srai_src_a", ex_src_a, 32'h80);
    check("srai_src_b", ex_src_b, 32'd4);
    offer(7'b1100011, 3'b110, 1'b0, 32'd7, 32'd9, 32'h40, 32'd0);
    step();
    check("bltu_ctrl", 32'(ex_alu_control), 32'b1011);
    check("bltu_funct3", 32'(ex_funct3), 32'b110);
    check("bltu_src_b", ex_src_b, 32'd9);
    offer(7'b1100011, 3'b000, 1'b0, 32'd7, 32'd9, 32'h40, 32'd0);
    step();
    check("beq_ctrl", 32'(ex_alu_control), 32'b0010);
    offer(7'b0010011, 3'b000, 1'b1, 32'd5, 32'd0, 32'd1, 32'd0);
    step();
    check("addi_f7_ctrl", 32'(ex_alu_control), 32'b0000);
    id_valid = 1'b0;
    step();
    check("idle_valid", 32'(ex_valid), 32'd0);

    // 3: stall with three ops offered
    ex_ready = 1'b0;
    offer(7'b0110011, 3'b110, 1'b0, 32'd1, 32'd0, 32'd0, 32'd0);
    step();
    check("stall_a_valid", 32'(ex_valid), 32'd1);
    check("stall_a_src", ex_src_a, 32'd1);
    check("stall_a_ready", 32'(id_ready), 32'd1);
    offer(7'b0110011, 3'b111, 1'b0, 32'd2, 32'd0, 32'd0, 32'd0);
    step();
    check("stall_b_ready", 32'(id_ready), 32'd0);
    check("stall_b_hold", ex_src_a, 32'd1);
    offer(7'b0110011, 3'b100, 1'b0, 32'd3, 32'd0, 32'd0, 32'd0);
    step();
    check("stall_c_ready", 32'(id_ready), 32'd0);
    check("stall_c_hold", ex_src_a, 32'd1);
    check("stall_c_ctrl", 32'(ex_alu_control), 32'b1100);
    ex_ready = 1'b1;
    step();
    check("drain_b_src", ex_src_a, 32'd2);
    check("drain_b_ctrl", 32'(ex_alu_control), 32'b1110);
    check("drain_b_ready", 32'(id_ready), 32'd1);
    step();
    check("drain_c_src", ex_src_a, 32'd3);
    check("drain_c_ctrl", 32'(ex_alu_control), 32'b1010);
    id_valid = 1'b0;
    step();
    check("drain_end_valid", 32'(ex_valid), 32'd0);

    // 4: flush with main and skid full and an op offered
    ex_ready = 1'b0;
    offer(7'b0110011, 3'b000, 1'b0, 32'h11, 32'd0, 32'd0, 32'd0);
    step();
    offer(7'b0110011, 3'b000, 1'b0, 32'h22, 32'd0, 32'd0, 32'd0);
    step();
    check("pre_flush_ready", 32'(id_ready), 32'd0);
    offer(7'b0110011, 3'b000, 1'b0, 32'h33, 32'd0, 32'd0, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    ex_ready = 1'b1;
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_ready", 32'(id_ready), 32'd1);
    step();
    check("flush_nothing", 32'(ex_valid), 32'd0);

    // 5: AUIPC, LUI, JAL, LOAD, illegal
    offer(7'b0010111, 3'b000, 1'b0, 32'h999, 32'd0, 32'h2000, 32'h100);
    step();
    check("auipc_src_a", ex_src_a, 32'h100);
    check("auipc_src_b", ex_src_b, 32'h2000);
    check("auipc_ctrl", 32'(ex_alu_control), 32'd0);
    offer(7'b0110111, 3'b000, 1'b0, 32'h999, 32'd0, 32'hABC000, 32'h100);
    step();
    check("lui_src_a", ex_src_a, 32'd0);
    check("lui_src_b", ex_src_b, 32'hABC000);
    offer(7'b1101111, 3'b000, 1'b0, 32'h999, 32'd0, 32'h80, 32'h200);
    step();
    check("jal_src_a", ex_src_a, 32'h200);
    check("jal_src_b", ex_src_b, 32'd4);
    offer(7'b0000011, 3'b010, 1'b0, 32'h1000, 32'd0, 32'h8, 32'd0);
    step();
    check("load_src_a", ex_src_a, 32'h1000);
    check("load_src_b", ex_src_b, 32'h8);
    check("load_illegal", 32'(ex_illegal), 32'd0);
    offer(7'h7F, 3'b000, 1'b1, 32'h999, 32'h777, 32'h55, 32'h100);
    step();
    check("illegal_flag", 32'(ex_illegal), 32'd1);
    check("illegal_ctrl", 32'(ex_alu_control), 32'd0);
    check("illegal_src_a", ex_src_a, 32'd0);
    check("illegal_src_b", ex_src_b, 32'd0);

    // 6: forwarding
    id_rs1 = 5'd5; id_rs2 = 5'd7;
    fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hDEAD;
    offer(7'b0110011, 3'b000, 1'b0, 32'h1234, 32'h5678, 32'd0, 32'd0);
    step();
`ifdef ALU_ISSUE_FWD_EN
    check("fwd_rs1", ex_src_a, 32'hDEAD);
`else
    check("nofwd_rs1", ex_src_a, 32'h1234);
`endif
    check("fwd_rs1_only_b", ex_src_b, 32'h5678);
    fwd_rd = 5'd7;
    step();
`ifdef ALU_ISSUE_FWD_EN
    check("fwd_rs2", ex_rs2_data, 32'hDEAD);
`else
    check("nofwd_rs2", ex_rs2_data, 32'h5678);
`endif
    check("fwd_rs2_only_a", ex_src_a, 32'h1234);
    id_rs1 = 5'd0; fwd_rd = 5'd0;
    step();
    check("fwd_x0", ex_src_a, 32'h1234);
    fwd_valid = 1'b0;

    // Reset mid-transfer with main and skid full
    ex_ready = 1'b0;
    offer(7'b0110011, 3'b000, 1'b0, 32'h44, 32'd0, 32'd0, 32'd0);
    step();
    step();
    id_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(ex_valid), 32'd0);
    check("midrst_ready", 32'(id_ready), 32'd1);
    check("midrst_src_a", ex_src_a, 32'd0);
    rst_n = 1'b1;
    ex_ready = 1'b1;
    step();
    step();
    check("midrst_nothing", 32'(ex_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
